// File: rtl/axi_lite_async_fifo.sv
// AXI4-Lite slave fronting a FIFO: the bus pushes, peeks and reads status; a peripheral pops
// through a rising-edge pulse port. Sticky full/empty interrupts. Everything runs on clk_axi.
module axi_lite_async_fifo #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk_axi,
    input  logic                  axi_resetn_i,
    input  logic                  clk_periph,
    input  logic [ADDR_WIDTH-1:0] axi_awaddr_i,
    input  logic                  axi_awvalid_i,
    output logic                  axi_awready_o,
    input  logic [DATA_WIDTH-1:0] axi_wdata_i,
    input  logic [3:0]            axi_wstrb_i,
    input  logic                  axi_wvalid_i,
    output logic                  axi_wready_o,
    output logic [1:0]            axi_bresp_o,
    output logic                  axi_bvalid_o,
    input  logic                  axi_bready_i,
    input  logic [ADDR_WIDTH-1:0] axi_araddr_i,
    input  logic                  axi_arvalid_i,
    output logic                  axi_arready_o,
    output logic [DATA_WIDTH-1:0] axi_rdata_o,
    output logic [1:0]            axi_rresp_o,
    output logic                  axi_rvalid_o,
    input  logic                  axi_rready_i,
    input  logic                  periph_rd_en_i,
    output logic [DATA_WIDTH-1:0] periph_rdata_o,
    output logic                  periph_rvalid_o,
    output logic                  periph_empty_o,
    output logic                  periph_full_o,
    input  logic                  irq_clear_full_i,
    input  logic                  irq_clear_empty_i,
    output logic                  irq_full_o,
    output logic                  irq_empty_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wr_ready;
    logic                  r_bvalid;
    logic [1:0]            r_bresp;
    logic                  r_arready;
    logic                  r_rvalid;
    logic [1:0]            r_rresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rd_en_q;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic                  r_prvalid;
    logic                  r_irq_full;
    logic                  r_irq_empty;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_hs;
    logic                  w_rd_hs;
    logic                  w_wr_addr_ok;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count_next;
    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]            w_rd_resp;
    logic                  w_unused;

    assign w_unused     = ^{clk_periph, axi_wstrb_i};
    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == CNT_FULL);
    assign w_head       = r_mem[r_rptr];
    assign w_wr_hs      = r_wr_ready && axi_awvalid_i && axi_wvalid_i;
    assign w_rd_hs      = r_arready && axi_arvalid_i;
    assign w_wr_addr_ok = (axi_awaddr_i == '0);
    // Push and pop both qualify against the pre-cycle count, so a full FIFO rejects a push
    // even when a pop lands on the same edge, and vice versa for empty.
    assign w_push       = w_wr_hs && w_wr_addr_ok && !w_full;
    assign w_pop        = periph_rd_en_i && !r_rd_en_q && !w_empty;
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    always_comb begin
        w_rd_data = '0;
        w_rd_resp = RESP_OKAY;
        case (axi_araddr_i)
            ADDR_WIDTH'(0): begin
                w_rd_data[0]    = w_empty;
                w_rd_data[1]    = w_full;
                w_rd_data[15:8] = 8'(r_count);
            end
            ADDR_WIDTH'(4): begin
                if (w_empty) w_rd_resp = RESP_SLVERR;
                else         w_rd_data = w_head;
            end
            ADDR_WIDTH'(8): w_rd_data = DATA_WIDTH'(r_count);
            default:        w_rd_resp = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clk_axi) begin
        if (w_push) r_mem[r_wptr] <= axi_wdata_i;
    end

    always_ff @(posedge clk_axi or negedge axi_resetn_i) begin
        if (!axi_resetn_i) begin
            r_wr_ready <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
        end else if (w_wr_hs) begin
            r_wr_ready <= 1'b0;
            r_bvalid   <= 1'b1;
            r_bresp    <= (w_wr_addr_ok && !w_full) ? RESP_OKAY : RESP_SLVERR;
        end else begin
            r_wr_ready <= !r_wr_ready && !r_bvalid && axi_awvalid_i && axi_wvalid_i;
            if (r_bvalid && axi_bready_i) r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk_axi or negedge axi_resetn_i) begin
        if (!axi_resetn_i) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else if (w_rd_hs) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rresp   <= w_rd_resp;
            r_rdata   <= w_rd_data;
        end else begin
            r_arready <= !r_arready && !r_rvalid && axi_arvalid_i;
            if (r_rvalid && axi_rready_i) r_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk_axi or negedge axi_resetn_i) begin
        if (!axi_resetn_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rd_en_q <= 1'b0;
            r_prdata  <= '0;
            r_prvalid <= 1'b0;
        end else begin
            r_rd_en_q <= periph_rd_en_i;
            r_count   <= w_count_next;
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (periph_rd_en_i && !r_rd_en_q) begin
                r_prvalid <= !w_empty;
                if (!w_empty) begin
                    r_prdata <= w_head;
                    r_rptr   <= r_rptr + PTR_W'(1);
                end
            end
        end
    end

    // A set condition takes priority over a clear held in the same cycle.
    always_ff @(posedge clk_axi or negedge axi_resetn_i) begin
        if (!axi_resetn_i) begin
            r_irq_full  <= 1'b0;
            r_irq_empty <= 1'b0;
        end else begin
            if (w_count_next == CNT_FULL && !w_full) r_irq_full <= 1'b1;
            else if (irq_clear_full_i)               r_irq_full <= 1'b0;
            if (w_count_next == '0 && !w_empty)      r_irq_empty <= 1'b1;
            else if (irq_clear_empty_i)              r_irq_empty <= 1'b0;
        end
    end

    assign axi_awready_o   = r_wr_ready;
    assign axi_wready_o    = r_wr_ready;
    assign axi_bvalid_o    = r_bvalid;
    assign axi_bresp_o     = r_bresp;
    assign axi_arready_o   = r_arready;
    assign axi_rvalid_o    = r_rvalid;
    assign axi_rresp_o     = r_rresp;
    assign axi_rdata_o     = r_rdata;
    assign periph_rdata_o  = r_prdata;
    assign periph_rvalid_o = r_prvalid;
    assign periph_empty_o  = w_empty;
    assign periph_full_o   = w_full;
    assign irq_full_o      = r_irq_full;
    assign irq_empty_o     = r_irq_empty;
endmodule

// File: tb/tb_axi_lite_async_fifo.sv
// Bench for axi_lite_async_fifo: directed walk through the main scenarios, then random traffic,
// all scored against a queue-based model of the FIFO, response codes and sticky interrupts.
`timescale 1ns/1ps
module tb_axi_lite_async_fifo;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int LIM   = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clk_periph = 1'b0;
    logic [AW-1:0] awaddr = '0;
    logic          awvalid = 1'b0;
    logic          awready;
    logic [DW-1:0] wdata = '0;
    logic [3:0]    wstrb = 4'hF;
    logic          wvalid = 1'b0;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready = 1'b0;
    logic [AW-1:0] araddr = '0;
    logic          arvalid = 1'b0;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready = 1'b0;
    logic          prd_en = 1'b0;
    logic [DW-1:0] prdata;
    logic          prvalid;
    logic          pempty;
    logic          pfull;
    logic          clr_full = 1'b0;
    logic          clr_empty = 1'b0;
    logic          irq_full;
    logic          irq_empty;

    always #5 clk = ~clk;

    axi_lite_async_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_axi(clk), .axi_resetn_i(rst_n), .clk_periph(clk_periph),
        .axi_awaddr_i(awaddr), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_araddr_i(araddr), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rvalid_o(rvalid), .axi_rready_i(rready),
        .periph_rd_en_i(prd_en), .periph_rdata_o(prdata), .periph_rvalid_o(prvalid),
        .periph_empty_o(pempty), .periph_full_o(pfull),
        .irq_clear_full_i(clr_full), .irq_clear_empty_i(clr_empty),
        .irq_full_o(irq_full), .irq_empty_o(irq_empty)
    );

    int          total = 0;
    int          bad = 0;
    logic [31:0] q[$];
    logic        m_irq_full = 1'b0;
    logic        m_irq_empty = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_irq(input int c0);
        if (q.size() == DEPTH && c0 != DEPTH) m_irq_full = 1'b1;
        if (q.size() == 0 && c0 != 0)         m_irq_empty = 1'b1;
    endtask

    task automatic check_flags();
        check("empty_flag", pempty, q.size() == 0);
        check("full_flag", pfull, q.size() == DEPTH);
        check("irq_full", irq_full, m_irq_full);
        check("irq_empty", irq_empty, m_irq_empty);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input bit with_pop,
                             output logic [1:0] resp, output logic pv, output logic [31:0] pd);
        int n;
        @(negedge clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!awready && n < LIM) begin @(negedge clk); n++; end
        check("aw_timeout", 32'(n >= LIM), 0);
        check("wready", wready, 1);
        if (with_pop) prd_en = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        check("awready_pulse", awready, 0);
        n = 0;
        while (!bvalid && n < LIM) begin @(negedge clk); n++; end
        check("b_timeout", 32'(n >= LIM), 0);
        resp = bresp; pv = prvalid; pd = prdata;
        prd_en = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        check("bvalid_clear", bvalid, 0);
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        n = 0;
        while (!arready && n < LIM) begin @(negedge clk); n++; end
        check("ar_timeout", 32'(n >= LIM), 0);
        @(negedge clk);
        arvalid = 1'b0;
        check("arready_pulse", arready, 0);
        n = 0;
        while (!rvalid && n < LIM) begin @(negedge clk); n++; end
        check("r_timeout", 32'(n >= LIM), 0);
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("rvalid_clear", rvalid, 0);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input bit with_pop);
        logic [1:0]  resp;
        logic        pv;
        logic [31:0] pd;
        int          c0;
        bit          push_ok;
        bit          pop_ok;
        c0 = q.size();
        push_ok = (a == 4'h0) && (c0 < DEPTH);
        pop_ok = with_pop && (c0 > 0);
        axi_write(a, d, with_pop, resp, pv, pd);
        check("bresp", resp, push_ok ? 2'b00 : 2'b10);
        if (with_pop) begin
            check("wp_pop_valid", pv, pop_ok);
            if (pop_ok) begin
                check("wp_pop_data", pd, q[0]);
                void'(q.pop_front());
            end
        end
        if (push_ok) q.push_back(d);
        model_irq(c0);
        $display("wr  a=%h d=%08h pop=%0d resp=%0d count=%0d", a, d, with_pop, resp, q.size());
        check_flags();
    endtask

    task automatic do_read(input logic [3:0] a, output logic [31:0] d);
        logic [1:0]  resp;
        logic [31:0] ed;
        logic [1:0]  er;
        er = 2'b00;
        case (a)
            4'h0: ed = {16'h0, 8'(q.size()), 6'h0, q.size() == DEPTH, q.size() == 0};
            4'h4: begin
                if (q.size() == 0) begin ed = 32'h0; er = 2'b10; end
                else ed = q[0];
            end
            4'h8: ed = 32'(q.size());
            default: begin ed = 32'h0; er = 2'b10; end
        endcase
        axi_read(a, d, resp);
        check("rdata", d, ed);
        check("rresp", resp, er);
        $display("rd  a=%h d=%08h resp=%0d", a, d, resp);
    endtask

    task automatic do_pop();
        int c0;
        c0 = q.size();
        @(negedge clk);
        prd_en = 1'b1;
        @(negedge clk);
        check("pop_valid", prvalid, c0 > 0);
        if (c0 > 0) begin
            check("pop_data", prdata, q[0]);
            void'(q.pop_front());
        end
        prd_en = 1'b0;
        model_irq(c0);
        $display("pop valid=%0d d=%08h count=%0d", prvalid, prdata, q.size());
        check_flags();
    endtask

    task automatic do_clear(input bit f, input bit e);
        @(negedge clk);
        clr_full = f; clr_empty = e;
        @(negedge clk);
        clr_full = 1'b0; clr_empty = 1'b0;
        if (f) m_irq_full = 1'b0;
        if (e) m_irq_empty = 1'b0;
        $display("clr full=%0d empty=%0d", f, e);
        check_flags();
    endtask

    initial begin
        logic [31:0] rd;
        int          n;
        repeat (3) @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_prdata", prdata, 0);
        check("rst_prvalid", prvalid, 0);
        check_flags();
        rst_n = 1'b1;

        do_write(4'h0, 32'hDEADBEEF, 1'b0);
        do_write(4'h0, 32'hFEEDCAFE, 1'b0);
        do_read(4'h0, rd);  check("tp_status2", rd, 32'h0000_0200);
        do_read(4'h4, rd);  check("tp_peek", rd, 32'hDEADBEEF);
        do_read(4'h8, rd);  check("tp_count2", rd, 32'd2);
        do_pop();
        do_pop();
        check("tp_irq_empty", irq_empty, 1);
        do_read(4'h0, rd);  check("tp_status_empty", rd, 32'h0000_0001);
        do_read(4'h4, rd);
        do_clear(1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) do_write(4'h0, 32'h100 + 32'(i), 1'b0);
        check("tp_full", pfull, 1);
        check("tp_irq_full", irq_full, 1);
        do_write(4'h0, 32'h0BAD0BAD, 1'b0);
        do_read(4'h4, rd);  check("tp_head_after_full", rd, 32'h100);
        do_read(4'h0, rd);  check("tp_status_full", rd, 32'h0000_0802);
        do_clear(1'b1, 1'b0);
        check("tp_irq_full_clr", irq_full, 0);
        for (int i = 0; i < 4; i++) do_pop();
        do_write(4'h0, 32'hC0FFEE00, 1'b1);
        do_read(4'h8, rd);  check("tp_count4", rd, 32'd4);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 1) do_pop();
            else do_write(4'h0, 32'h5000 + 32'(i), 1'b0);
        end
        do_write(4'hC, 32'h12345678, 1'b0);

        for (int i = 0; i < 250; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 33)      do_write(4'h0, $urandom, 1'b0);
            else if (r < 45) do_write(4'h0, $urandom, 1'b1);
            else if (r < 50) do_write(4'($urandom_range(1, 15)), $urandom, 1'($urandom_range(0, 1)));
            else if (r < 75) do_pop();
            else if (r < 92) do_read(4'($urandom_range(0, 3) * 4 + ((r == 91) ? 1 : 0)), rd);
            else             do_clear(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a write response: response and contents must vanish at once.
        if (q.size() == 0) do_write(4'h0, 32'hA5A5A5A5, 1'b0);
        @(negedge clk);
        awaddr = 4'h0; wdata = 32'h77777777; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        while (!bvalid && n < LIM) begin @(negedge clk); n++; end
        check("mid_b_timeout", 32'(n >= LIM), 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_awready", awready, 0);
        check("mid_rst_prvalid", prvalid, 0);
        awvalid = 1'b0; wvalid = 1'b0;
        q.delete();
        m_irq_full = 1'b0; m_irq_empty = 1'b0;
        check_flags();
        @(negedge clk);
        rst_n = 1'b1;
        do_write(4'h0, 32'h13579BDF, 1'b0);
        do_pop();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axi_lite_async_fifo.md
# axi_lite_async_fifo

AXI4-Lite slave front-end to a FIFO, `FIFO_DEPTH` entries deep and `DATA_WIDTH` bits wide. A bus master pushes words and reads status or peeks the head over AXI4-Lite. A peripheral pops words through a simple pulse/valid port, and two sticky interrupts flag full and empty events. All state is in the `clk_axi` domain; the block sits between the system interconnect and a streaming consumer.

## Interface
- One clock (`clk_axi`); reset `axi_resetn_i` is asynchronous and active-low.
- `ADDR_WIDTH`, 4, AXI address width.
- `DATA_WIDTH`, 32, data and entry width.
- `FIFO_DEPTH`, 8, entry count; power of two, ≥2.
- `clk_axi` in 1: the single clock; all logic is on its rising edge.
- `axi_resetn_i` in 1: async active-low reset.
- `clk_periph` in 1: unused; pin compatibility only.
- `axi_awaddr_i` in ADDR_WIDTH, `axi_awvalid_i` in 1, `axi_awready_o` out 1.
- `axi_wdata_i` in DATA_WIDTH, `axi_wstrb_i` in 4 (ignored; full-word writes), `axi_wvalid_i` in 1, `axi_wready_o` out 1.
- `axi_bresp_o` out 2, `axi_bvalid_o` out 1, `axi_bready_i` in 1.
- `axi_araddr_i` in ADDR_WIDTH, `axi_arvalid_i` in 1, `axi_arready_o` out 1.
- `axi_rdata_o` out DATA_WIDTH, `axi_rresp_o` out 2, `axi_rvalid_o` out 1, `axi_rready_i` in 1.
- `periph_rd_en_i` in 1: pop request. A rising edge requests one pop.
- `periph_rdata_o` out DATA_WIDTH: popped word.
- `periph_rvalid_o` out 1: popped word valid.
- `periph_empty_o` out 1, `periph_full_o` out 1: combinational flags.
- `irq_clear_full_i` in 1, `irq_clear_empty_i` in 1: level clears.
- `irq_full_o` out 1, `irq_empty_o` out 1: sticky interrupts.

## Operation
- Storage: `FIFO_DEPTH`×`DATA_WIDTH` array.
- Read and write pointers wrap modulo `FIFO_DEPTH`.
- `count` width is log2(FIFO_DEPTH)+1.
- `empty` = (count==0); `full` = (count==FIFO_DEPTH).
- Write map:
  - 0x0 pushes WDATA: BRESP=OKAY(00) if not full, else SLVERR(10) with data dropped.
  - Any other address: SLVERR, no push.
- Read map:
  - 0x0 status: bit0=empty, bit1=full, bits[15:8]=count, rest 0.
  - 0x4 peek: returns head entry with OKAY. If empty, returns 0 with SLVERR. No pop.
  - 0x8: returns count, OKAY.
  - Other addresses: 0 with SLVERR.
- Pop: `rd_en_q` registers `periph_rd_en_i`. A pop is requested when `periph_rd_en_i && !rd_en_q`.
  - If not empty: `periph_rdata_o` ← head, `periph_rvalid_o`←1, read pointer advances.
  - If empty: `periph_rvalid_o`←0, nothing popped.
  - Data and valid hold until the next pop request.
- Push and pop in the same cycle:
  - Both evaluate against pre-cycle count; count is unchanged.
  - Push while full is rejected even if a pop occurs in that cycle.
  - Pop while empty is ignored even if a push occurs.
- `irq_full_o` sets on the cycle count becomes FIFO_DEPTH.
- `irq_empty_o` sets on the cycle count goes from nonzero to 0.
- Each interrupt clears while its clear input is high. If set and clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - All ready/valid outputs 0.
  - `axi_bresp_o`=0, `axi_rresp_o`=0, `axi_rdata_o`=0.
  - `periph_rdata_o`=0, `periph_rvalid_o`=0.
  - Both IRQs 0.
  - Pointers and count 0, so `periph_empty_o`=1, `periph_full_o`=0.
- Write channel:
  - `axi_awready_o` and `axi_wready_o` are registered and pulse together for exactly one cycle.
  - The pulse rises on the edge after both valids are seen high, provided `axi_bvalid_o`=0 and ready is not already high.
  - The push and the BRESP decision happen on the handshake edge.
  - `axi_bvalid_o` rises on that same edge and holds with BRESP until `axi_bready_i`.
- Read channel:
  - `axi_arready_o` pulses one cycle under the same rule, gated by `axi_rvalid_o`=0.
  - RDATA/RRESP are captured on the handshake edge.
  - `axi_rvalid_o` rises on that edge and holds until `axi_rready_i`.
- Pop latency: data is valid on the first `clk_axi` edge where `periph_rd_en_i` is high after being low. Flags update on the same edge.
- A reset assertion mid-transaction aborts it immediately. Pending responses are dropped and FIFO contents are discarded.

## Test plan
- Reset, then write 0xDEADBEEF and 0xFEEDCAFE to 0x0 -> both BRESP=00; status read at 0x0 = 0x00000200.
- Peek 0x4 -> 0xDEADBEEF, RRESP=00; status count stays 2.
- Peripheral pops twice -> 0xDEADBEEF then 0xFEEDCAFE with `periph_rvalid_o`=1; `irq_empty_o` sets; status reads 0x00000001.
- Peek on empty -> RDATA=0, RRESP=10.
- Write 8 words -> `periph_full_o`=1, `irq_full_o`=1. A 9th write -> BRESP=10 and contents unchanged. Pulse `irq_clear_full_i` -> `irq_full_o`=0.
- 20 interleaved push/pop cycles crossing pointer wrap, plus a simultaneous push/pop at count 4 -> data in order and count stays 4; write to 0xC -> BRESP=10.
